// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram_fifo_ctrl. The environment (upstream, downstream
// and the external dual-port RAM) uses the master view; the FIFO controller uses the slave view.
interface ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  // Upstream stream: word transfers on an edge where S_VALID && S_READY.
  // Downstream stream: word transfers on an edge where M_VALID && M_READY.
  // S_READY and M_VALID depend only on stored state, never on the partner's
  // VALID/READY, so neither side may wait for the other before asserting its own.
  logic [DATA_WIDTH-1:0] S_DATA;
  logic                  S_VALID;
  logic                  S_READY;
  logic [DATA_WIDTH-1:0] M_DATA;
  logic                  M_VALID;
  logic                  M_READY;
  logic                  RAM_W_EN;
  logic [ADDR_WIDTH-1:0] RAM_W_ADDR;
  logic [DATA_WIDTH-1:0] RAM_W_DATA;
  logic [ADDR_WIDTH-1:0] RAM_R_ADDR;
  logic [DATA_WIDTH-1:0] RAM_R_DATA;

  modport master (
    output S_DATA, S_VALID, M_READY, RAM_R_DATA,
    input  S_READY, M_DATA, M_VALID, RAM_W_EN, RAM_W_ADDR, RAM_W_DATA, RAM_R_ADDR
  );

  modport slave (
    input  S_DATA, S_VALID, M_READY, RAM_R_DATA,
    output S_READY, M_DATA, M_VALID, RAM_W_EN, RAM_W_ADDR, RAM_W_DATA, RAM_R_ADDR
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external dual-port RAM
// (port A writes, port B combinational read). Define RAM_FIFO_LEVEL_EN to add LEVEL/ALMOST_FULL.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                ACLK,
  input  logic                ARESET,
  ram_fifo_ctrl_if.slave      bus,
  output logic                EMPTY,
  output logic                FULL
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0] LEVEL,
  output logic                ALMOST_FULL
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull_thresh
    $error("ram_fifo_ctrl: AFULL_THRESH must lie in 1..2**ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  always_comb begin
    full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
            (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    // Reset wins over any transfer in the same cycle, so no RAM write either.
    push  = bus.S_VALID && !full && !ARESET;
    pop   = bus.M_READY && !empty && !ARESET;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ARESET) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge ACLK) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
  end

  // S_READY and M_VALID come from state only; a pop at full frees space for the next cycle.
  assign bus.S_READY    = !full;
  assign bus.M_VALID    = !empty;
  assign bus.M_DATA     = bus.RAM_R_DATA;
  assign bus.RAM_W_EN   = push;
  assign bus.RAM_W_ADDR = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bus.RAM_W_DATA = bus.S_DATA;
  assign bus.RAM_R_ADDR = rd_ptr_q[ADDR_WIDTH-1:0];
  assign EMPTY          = empty;
  assign FULL           = full;

`ifdef RAM_FIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] THRESH = (ADDR_WIDTH + 1)'(AFULL_THRESH);

  // Kept as its own register so LEVEL is a clean flop output rather than a subtractor.
  logic [ADDR_WIDTH:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (ARESET) begin
      level_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level_d = level_q + PTR_ONE;
        2'b01:   level_d = level_q - PTR_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    level_q <= level_d;
  end

  assign LEVEL       = level_q;
  assign ALMOST_FULL = (level_q >= THRESH);
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomised scoreboard bench for ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
// Compile with RAM_FIFO_LEVEL_EN defined to also check LEVEL and ALMOST_FULL.
module tb_ram_fifo_ctrl;
  localparam int DW     = 32;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int THRESH = 12;

  logic ACLK;
  logic ARESET;
  logic EMPTY;
  logic FULL;
`ifdef RAM_FIFO_LEVEL_EN
  logic [AW:0] LEVEL;
  logic        ALMOST_FULL;
`endif

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(THRESH)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .bus         (bus.slave),
    .EMPTY       (EMPTY),
    .FULL        (FULL)
`ifdef RAM_FIFO_LEVEL_EN
    ,
    .LEVEL       (LEVEL),
    .ALMOST_FULL (ALMOST_FULL)
`endif
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- external dual-port RAM ----------------
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge ACLK) if (bus.RAM_W_EN) mem[bus.RAM_W_ADDR] <= bus.RAM_W_DATA;
  assign bus.RAM_R_DATA = mem[bus.RAM_R_ADDR];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: checks at the falling edge, then advances the model by what the next rising edge does.
  initial begin
    wr_cnt = '0;
    rd_cnt = '0;
  end

  always @(negedge ACLK) begin
    int sz;
    logic exp_wen;
    sz = exp_q.size();
    exp_wen = !ARESET && bus.S_VALID && (sz < DEPTH);
    check("empty",   {31'b0, EMPTY},        {31'b0, sz == 0});
    check("full",    {31'b0, FULL},         {31'b0, sz == DEPTH});
    check("s_ready", {31'b0, bus.S_READY},  {31'b0, sz < DEPTH});
    check("m_valid", {31'b0, bus.M_VALID},  {31'b0, sz > 0});
    check("w_en",    {31'b0, bus.RAM_W_EN}, {31'b0, exp_wen});
    check("r_addr",  {28'b0, bus.RAM_R_ADDR}, {28'b0, rd_cnt});
    if (exp_wen) begin
      check("w_addr", {28'b0, bus.RAM_W_ADDR}, {28'b0, wr_cnt});
      check("w_data", bus.RAM_W_DATA, bus.S_DATA);
    end
    if (sz > 0) check("m_data", bus.M_DATA, exp_q[0]);
`ifdef RAM_FIFO_LEVEL_EN
    check("level",       {27'b0, LEVEL},       sz);
    check("almost_full", {31'b0, ALMOST_FULL}, {31'b0, sz >= THRESH});
`endif
    if (ARESET) begin
      exp_q.delete();
      wr_cnt = '0;
      rd_cnt = '0;
    end else begin
      if (bus.M_READY && sz > 0) begin
        void'(exp_q.pop_front());
        rd_cnt = rd_cnt + 1'b1;
      end
      if (bus.S_VALID && sz < DEPTH) begin
        exp_q.push_back(bus.S_DATA);
        wr_cnt = wr_cnt + 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic rs);
    bus.S_VALID = v;
    bus.S_DATA  = d;
    bus.M_READY = r;
    ARESET      = rs;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int thr_v;
    int thr_r;
    ARESET      = 1'b1;
    bus.S_VALID = 1'b1;
    bus.S_DATA  = 32'hDEAD_BEEF;
    bus.M_READY = 1'b0;

    // reset held with upstream valid
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    cyc(1'b1, 32'hCAFE_F00D, 1'b1, 1'b1);

    // fill to full, then one ignored extra word
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // drain, plus a pop attempt while empty
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // wrap: 24 pushes with pops lagging by one cycle
    for (int i = 0; i <= 24; i++) cyc(i < 24, $urandom, i >= 1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // simultaneous push/pop with three words stored
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    // at full: pop with upstream valid, then keep pushing
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, 32'h5A5A_0001, 1'b1, 1'b0);
    cyc(1'b1, 32'h5A5A_0002, 1'b0, 1'b0);
    cyc(1'b1, 32'h5A5A_0003, 1'b0, 1'b0);

    // mid-fill reset
    cyc(1'b1, '0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, 32'h7777, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // random traffic with shifting valid/ready biases and rare resets
    thr_v = 50;
    thr_r = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        thr_v = $urandom_range(10, 90);
        thr_r = $urandom_range(10, 90);
      end
      cyc($urandom_range(0, 99) < thr_v, $urandom, $urandom_range(0, 99) < thr_r,
          $urandom_range(0, 299) == 0);
    end

    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    @(negedge ACLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
